fetch_unit: RTL

- Instruction fetch stage, directly upstream of main_decoder in the RISC-V CPU.
- Holds the PC and issues word requests to instruction memory with a request/ready handshake.
- Buffers returned instructions in a 2-entry queue and presents one instruction per cycle, with opcode, pc and pc_plus4, to decode.
- Supports a stall from downstream and a redirect (branch/jal target) that flushes in-flight work.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: RV32 base opcodes, canonical NOP and datapath width.
`default_nettype none

package cpu_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {instruction, pc} with push, pop, flush and count.
`default_nettype none

module fetch_queue import cpu_pkg::*; #(
  parameter int DW = XLEN
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] push_instr_i,
  input  logic [DW-1:0] push_pc_i,
  output logic [DW-1:0] head_instr_o,
  output logic [DW-1:0] head_pc_o,
  output logic [1:0]    count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] instr_q [2];
  logic [DW-1:0] pc_q    [2];
  logic          rd_q, wr_q;
  logic [1:0]    count_q;
  logic          w_push, w_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign w_push  = push_i && (!full_o || pop_i);
  assign w_pop   = pop_i && !empty_o;

  assign head_instr_o = instr_q[rd_q];
  assign head_pc_o    = pc_q[rd_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (flush_i) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      if (w_push) wr_q <= ~wr_q;
      if (w_pop)  rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload needs no reset: empty_o gates every consumer of the head.
  always_ff @(posedge clock) begin
    if (w_push && !flush_i) begin
      instr_q[wr_q] <= push_instr_i;
      pc_q[wr_q]    <= push_pc_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request/ready handshake, 2-deep instruction queue, redirect with kill.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the sticky fetch_misaligned halt.
`default_nettype none

module fetch_unit import cpu_pkg::NOP_INSTR; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_request,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);

  logic            req_q, req_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] last_pc_q;

  logic [XLEN-1:0] w_tgt, w_base_pc, w_head_instr, w_head_pc;
  logic [1:0]      w_count, w_cnt_next;
  logic            w_xfer, w_busy, w_push, w_pop, w_issue, w_halt_next;
  logic            w_full, w_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q;
  assign w_tgt       = redirect_target;
  assign w_halt_next = halt_q || (redirect && (redirect_target[1:0] != 2'b00));
  assign fetch_misaligned = halt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) halt_q <= 1'b0;
    else        halt_q <= w_halt_next;
  end
`else
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^redirect_target[1:0];
  assign w_tgt       = {redirect_target[XLEN-1:2], 2'b00};
  assign w_halt_next = 1'b0;
`endif

  assign w_xfer = req_q && imem_ready;
  assign w_busy = req_q && !imem_ready;
  // Redirect flushes the queue, so a completing transfer in that cycle is dropped too.
  assign w_push = w_xfer && !kill_q && !redirect;
  assign w_pop  = !w_empty && !stall && !redirect;

  assign w_cnt_next = redirect ? 2'd0 : (w_count + {1'b0, w_push} - {1'b0, w_pop});
  assign w_base_pc  = redirect ? w_tgt : fetch_pc_q;
  // A held request counts as outstanding, so only issue once it is gone and room remains.
  assign w_issue    = !w_busy && (w_cnt_next < 2'd2) && !w_halt_next;

  always_comb begin
    req_d      = w_busy || w_issue;
    addr_d     = w_issue ? w_base_pc : addr_q;
    fetch_pc_d = w_issue ? (w_base_pc + XLEN'(4)) : w_base_pc;
    kill_d     = kill_q;
    if (redirect && w_busy) kill_d = 1'b1;
    else if (w_xfer)        kill_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q      <= 1'b0;
      kill_q     <= 1'b0;
      addr_q     <= XLEN'(RESET_PC);
      fetch_pc_q <= XLEN'(RESET_PC);
      last_pc_q  <= XLEN'(RESET_PC);
    end else begin
      req_q      <= req_d;
      kill_q     <= kill_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      if (!w_empty) last_pc_q <= w_head_pc;
    end
  end

  fetch_queue #(
    .DW (XLEN)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .push_i       (w_push),
    .pop_i        (w_pop),
    .flush_i      (redirect),
    .push_instr_i (imem_rdata),
    .push_pc_i    (addr_q),
    .head_instr_o (w_head_instr),
    .head_pc_o    (w_head_pc),
    .count_o      (w_count),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

  logic w_unused_full;
  assign w_unused_full = w_full;

  assign imem_request = req_q;
  assign imem_address = addr_q;
  assign instr_valid  = !w_empty;
  assign instruction  = w_empty ? XLEN'(NOP_INSTR) : w_head_instr;
  assign opcode       = instruction[6:0];
  assign pc           = w_empty ? last_pc_q : w_head_pc;
  assign pc_plus4     = pc + XLEN'(4);

endmodule

`default_nettype wire
